// File: rtl/spi_regfile_periph_if.sv
// spi_regfile_periph_if: SPI mode-0 bus between a controller and the register-file peripheral
//   sclk    controller clock, idle low
//   cs_n    active-low chip select
//   copi    controller-out data, MSB first
//   cipo    peripheral-out data, MSB first
//   cipo_oe peripheral drives cipo during a read data phase
interface spi_regfile_periph_if;
   logic sclk;
   logic cs_n;
   logic copi;
   logic cipo;
   logic cipo_oe;
   modport master (output sclk, cs_n, copi, input cipo, cipo_oe);
   modport slave (input sclk, cs_n, copi, output cipo, cipo_oe);
endinterface

// File: rtl/spi_regfile_periph.sv
// spi_regfile_periph: SPI mode-0 register-file peripheral, fully in the clk domain
//   clk       system clock (>= 8x sclk)
//   rst_n     asynchronous active-low reset
//   spi       slave side of the SPI bus (sclk, cs_n, copi in; cipo, cipo_oe out)
//   regs      register contents, reg k at [k*DATA_W +: DATA_W]
//   wr_pulse  1-clk strobe on a committed write
//   wr_addr   address of the last committed write
//   frame_err 1-clk strobe on a frame of the wrong length
module spi_regfile_periph #(
   parameter int NUM_REGS    = 5,
   parameter int DATA_W      = 8,
   parameter int ADDR_W      = 7,
   parameter int SYNC_STAGES = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   spi_regfile_periph_if.slave          spi,
   output logic [NUM_REGS*DATA_W-1:0]   regs,
   output logic                         wr_pulse,
   output logic [ADDR_W-1:0]            wr_addr,
   output logic                         frame_err
);
   localparam int FRAME_W = 1 + ADDR_W + DATA_W;
   localparam int HDR_W   = 1 + ADDR_W;
   localparam int CW      = $clog2(FRAME_W + 2);
   typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;
   state_t                 state;
   logic [SYNC_STAGES-1:0] sclk_sy, cs_sy, copi_sy;
   logic                   sclk_s, cs_s, copi_s, sclk_d, cs_d;
   logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;
   logic [FRAME_W-1:0]     shreg;
   logic [CW-1:0]          bit_cnt;
   logic [DATA_W-1:0]      tx_shift, rd_val;
   logic [ADDR_W-1:0]      hdr_addr, fr_addr;
   logic                   wr_hit, cipo, cipo_oe;

   assign spi.cipo    = cipo;
   assign spi.cipo_oe = cipo_oe;
   assign sclk_s      = sclk_sy[SYNC_STAGES-1];
   assign cs_s        = cs_sy[SYNC_STAGES-1];
   assign copi_s      = copi_sy[SYNC_STAGES-1];
   assign sclk_rise   = sclk_s & ~sclk_d;
   assign sclk_fall   = ~sclk_s & sclk_d;
   assign cs_rise     = cs_s & ~cs_d;
   assign cs_fall     = ~cs_s & cs_d;
   assign hdr_addr    = shreg[ADDR_W-1:0];
   assign fr_addr     = shreg[FRAME_W-2 -: ADDR_W];

   // copi shares the sclk synchroniser depth so each sample lines up with its detected sclk rise
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         sclk_sy <= '0;
         cs_sy   <= '1;
         copi_sy <= '0;
         sclk_d  <= 1'b0;
         cs_d    <= 1'b1;
      end else begin
         sclk_sy <= {sclk_sy[SYNC_STAGES-2:0], spi.sclk};
         cs_sy   <= {cs_sy[SYNC_STAGES-2:0], spi.cs_n};
         copi_sy <= {copi_sy[SYNC_STAGES-2:0], spi.copi};
         sclk_d  <= sclk_s;
         cs_d    <= cs_s;
      end

   // address decode: read mux on the header address, hit flag on the full-frame address
   always_comb begin
      rd_val = '0;
      wr_hit = 1'b0;
      for (int k = 0; k < NUM_REGS; k++) begin
         if (hdr_addr == ADDR_W'(k)) rd_val = regs[k*DATA_W +: DATA_W];
         if (fr_addr == ADDR_W'(k)) wr_hit = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state     <= IDLE;
         shreg     <= '0;
         bit_cnt   <= '0;
         tx_shift  <= '0;
         regs      <= '0;
         cipo      <= 1'b0;
         cipo_oe   <= 1'b0;
         wr_pulse  <= 1'b0;
         wr_addr   <= '0;
         frame_err <= 1'b0;
      end else begin
         wr_pulse  <= 1'b0;
         frame_err <= 1'b0;
         if (cs_rise) begin
            state   <= IDLE;
            cipo    <= 1'b0;
            cipo_oe <= 1'b0;
            if (bit_cnt == CW'(FRAME_W)) begin
               if (shreg[FRAME_W-1] && wr_hit) begin
                  for (int k = 0; k < NUM_REGS; k++)
                     if (fr_addr == ADDR_W'(k)) regs[k*DATA_W +: DATA_W] <= shreg[DATA_W-1:0];
                  wr_pulse <= 1'b1;
                  wr_addr  <= fr_addr;
               end
            end else if (bit_cnt != '0) frame_err <= 1'b1;
         end else if (cs_fall) begin
            state   <= HDR;
            bit_cnt <= '0;
            shreg   <= '0;
            cipo    <= 1'b0;
            cipo_oe <= 1'b0;
         end else begin
            if (sclk_rise && !cs_s && state != IDLE) begin
               shreg <= {shreg[FRAME_W-2:0], copi_s};
               if (bit_cnt != CW'(FRAME_W + 1)) bit_cnt <= bit_cnt + 1'b1;
            end
            if (state == HDR && bit_cnt == CW'(HDR_W)) begin
               state <= DATA;
               if (!shreg[ADDR_W]) begin
                  tx_shift <= rd_val;
                  cipo     <= rd_val[DATA_W-1];
                  cipo_oe  <= 1'b1;
               end
            end
            // the fall ending the last header bit re-presents the MSB, so the
            // controller sees the MSB at the first data rise and the LSB at the last
            if (state == DATA && cipo_oe && sclk_fall) begin
               cipo     <= tx_shift[DATA_W-1];
               tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
            end
         end
      end
endmodule
